// File: rtl/nvm_core_addr_router_if.sv
// nvm_core_addr_router_if
//   Bus bundle between the Wishbone master, the address router and the
//   downstream regions of the SNN NVM core.
//   Signals:
//     wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i : master request
//     region_ack_i                              : per-region acknowledge from downstream
//     region_sel_o                              : registered one-hot region select
//     wbs_ack_o, wbs_err_o                      : single-cycle transfer response
//     done_pulse_o                              : acked write to the picture-done region
//     err_cnt_o                                 : saturating count of error responses
//   Modports: slave (router side), master (bus/bench side).
interface nvm_core_addr_router_if #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 3
);
  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [ADDR_W-1:0]      wbs_adr_i;
  logic [NUM_REGIONS-1:0] region_ack_i;
  logic [NUM_REGIONS-1:0] region_sel_o;
  logic                   wbs_ack_o;
  logic                   wbs_err_o;
  logic                   done_pulse_o;
  logic [7:0]             err_cnt_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, region_ack_i,
    output region_sel_o, wbs_ack_o, wbs_err_o, done_pulse_o, err_cnt_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, region_ack_i,
    input  region_sel_o, wbs_ack_o, wbs_err_o, done_pulse_o, err_cnt_o
  );
endinterface

// File: rtl/nvm_core_addr_router.sv
// nvm_core_addr_router
//   Registered Wishbone-slave address router for the SNN NVM core. Decodes a
//   region index from the bus address, drives a one-hot region select, waits
//   for that region's acknowledge and returns ack or err to the master. An
//   unmapped index or a BUSY phase of TIMEOUT cycles produces err. An acked
//   write to DONE_REGION raises done_pulse_o; error responses are counted in
//   a saturating 8-bit counter.
//   Ports:
//     wb_clk_i : clock
//     wb_rst_i : asynchronous reset, active-high
//     bus      : nvm_core_addr_router_if.slave (request, region select/ack, response)
module nvm_core_addr_router #(
  parameter int ADDR_W      = 32,
  parameter int SEL_LSB     = 12,
  parameter int SEL_W       = 4,
  parameter int NUM_REGIONS = 3,
  parameter int DONE_REGION = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  nvm_core_addr_router_if.slave       bus
);

  localparam int SEL_MSB = (SEL_LSB + SEL_W <= ADDR_W) ? (SEL_LSB + SEL_W - 1) : (ADDR_W - 1);
  localparam int TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   NUM_REG_EXT = (SEL_W + 1)'(NUM_REGIONS);
  localparam logic [SEL_W-1:0] DONE_IDX    = SEL_W'(DONE_REGION);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic                   we_q, we_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [7:0]             cnt_q;

  logic [SEL_W-1:0] adr_idx;
  logic             adr_mapped;
  logic             ack_hit;

  assign adr_idx    = bus.wbs_adr_i[SEL_MSB -: SEL_W];
  assign adr_mapped = ({1'b0, adr_idx} < NUM_REG_EXT);
  // sel_q is the one-hot of the latched index while BUSY, so masking with it
  // observes only the selected region's ack and ignores the others.
  assign ack_hit    = |(bus.region_ack_i & sel_q);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      timer_q <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    timer_d = timer_q;
    sel_d   = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          idx_d   = adr_idx;
          we_d    = bus.wbs_we_i;
          timer_d = '0;
          if (adr_mapped) begin
            state_d = BUSY;
            sel_d   = NUM_REGIONS'(1) << adr_idx;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        // Abort beats ack, ack beats timeout.
        if (!bus.wbs_cyc_i) begin
          state_d = IDLE;
        end else if (ack_hit) begin
          state_d = RESP;
          ack_d   = 1'b1;
          done_d  = we_q && (idx_q == DONE_IDX);
        end else if (timer_q == TMR_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          sel_d   = sel_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counts the cycles in which the registered err output is high.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (err_q && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.region_sel_o = sel_q;
  assign bus.wbs_ack_o    = ack_q;
  assign bus.wbs_err_o    = err_q;
  assign bus.done_pulse_o = done_q;
  assign bus.err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_nvm_core_addr_router.sv
module tb_nvm_core_addr_router;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nvm_core_addr_router_if #(.ADDR_W(32), .NUM_REGIONS(3)) bus ();

  nvm_core_addr_router #(
    .ADDR_W(32), .SEL_LSB(12), .SEL_W(4), .NUM_REGIONS(3),
    .DONE_REGION(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int compared = 0;
  int failed   = 0;
  int errs     = 0;   // error pulses expected so far since the last reset

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          d;      // ack raised for the edge ending BUSY cycle d+1
    logic [2:0]  sel;
    int          tend;   // response visible after edge tend (sampling edge = 0)
    logic        ack;
    logic        err;
    logic        done;
  } vec_t;

  function automatic logic [7:0] exp_cnt();
    return (errs > 255) ? 8'd255 : 8'(errs);
  endfunction

  function automatic logic [13:0] got_vec();
    return {bus.region_sel_o, bus.wbs_ack_o, bus.wbs_err_o, bus.done_pulse_o, bus.err_cnt_o};
  endfunction

  task automatic check(input string name, input int n, input logic [13:0] got, input logic [13:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got sel=%b ack=%b err=%b done=%b cnt=%0d, expected sel=%b ack=%b err=%b done=%b cnt=%0d",
               name, n, got[13:11], got[10], got[9], got[8], got[7:0],
               exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Reference model: outcome of one transaction from the routing rules.
  function automatic vec_t model(input logic [31:0] adr, input logic we, input int d);
    vec_t v;
    int idx;
    idx   = int'(adr[15:12]);
    v.adr = adr;
    v.we  = we;
    v.d   = d;
    if (idx < 3) begin
      v.sel  = 3'(1 << idx);
      v.ack  = (d < TIMEOUT);
      v.err  = !v.ack;
      v.tend = v.ack ? d + 1 : TIMEOUT;
      v.done = v.ack && we && (idx == 2);
    end else begin
      v.sel  = 3'b000;
      v.ack  = 1'b0;
      v.err  = 1'b1;
      v.tend = 0;
      v.done = 1'b0;
    end
    return v;
  endfunction

  task automatic run_txn(input string name, input vec_t v, input logic stray);
    logic [13:0] exp;
    bus.wbs_adr_i    = v.adr;
    bus.wbs_we_i     = v.we;
    bus.wbs_cyc_i    = 1'b1;
    bus.wbs_stb_i    = 1'b1;
    bus.region_ack_i = stray ? (3'($urandom) & ~v.sel) : 3'b000;
    for (int n = 0; n <= v.tend + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n < v.tend)       exp = {v.sel, 3'b000, exp_cnt()};
      else if (n == v.tend) exp = {3'b000, v.ack, v.err, v.done, exp_cnt()};
      else                  exp = {6'b0, exp_cnt()};
      check(name, n, got_vec(), exp);
      if (n == v.tend && v.err) errs++;
      bus.region_ack_i = (stray ? (3'($urandom) & ~v.sel) : 3'b000) | ((n == v.d) ? v.sel : 3'b000);
      if (n == v.tend) begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
      end
    end
    bus.region_ack_i = 3'b000;
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.wbs_cyc_i    = 1'b0;
    bus.wbs_stb_i    = 1'b0;
    bus.wbs_we_i     = 1'b0;
    bus.wbs_adr_i    = '0;
    bus.region_ack_i = '0;

    //           adr           we    d   sel     tend ack   err   done
    tbl[0] = '{32'h0000_0000, 1'b0, 0,  3'b001, 1,   1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_2000, 1'b1, 3,  3'b100, 4,   1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_2000, 1'b0, 3,  3'b100, 4,   1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_5000, 1'b0, 0,  3'b000, 0,   1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h0000_1000, 1'b0, 99, 3'b010, 16,  1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_1000, 1'b1, 15, 3'b010, 16,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h0000_3000, 1'b1, 0,  3'b000, 0,   1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'hFFFF_2ABC, 1'b1, 0,  3'b100, 1,   1'b1, 1'b0, 1'b1};
    tbl[8] = '{32'h0000_1000, 1'b1, 16, 3'b010, 16,  1'b0, 1'b1, 1'b0};

    // Asynchronous reset state.
    #1;
    check("reset", 0, got_vec(), 14'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 0, got_vec(), 14'b0);

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // Stray acks on other regions while region 1 is busy.
    run_txn("stray_r1", model(32'h0000_1000, 1'b0, 5), 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] adr;
      adr = $urandom;
      adr[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      v = model(adr, 1'($urandom), int'($urandom_range(0, TIMEOUT + 2)));
      run_txn($sformatf("rand%0d", i), v, 1'($urandom));
    end

    // Drop cyc mid-BUSY (stb held): abort to IDLE with no response.
    bus.wbs_adr_i = 32'h0000_1000;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort", n, got_vec(), (n < 3) ? {3'b010, 3'b000, exp_cnt()} : {6'b0, exp_cnt()});
      if (n == 2) bus.wbs_cyc_i = 1'b0;
    end
    bus.wbs_stb_i = 1'b0;

    // Reset mid-BUSY: select and counter clear before the next edge.
    bus.wbs_adr_i = 32'h0000_0000;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", n, got_vec(), {3'b001, 3'b000, exp_cnt()});
    end
    rst = 1'b1;
    #1;
    errs = 0;
    check("rst_mid_busy", 0, got_vec(), 14'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("after_rst", 0, got_vec(), 14'b0);

    // 300 back-to-back unmapped accesses with stb held: counter saturates.
    bus.wbs_adr_i = 32'h0000_5000;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b", n, got_vec(), (n % 2 == 0) ? {3'b000, 3'b010, exp_cnt()} : {6'b0, exp_cnt()});
      if (n % 2 == 0) errs++;
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cnt_saturated", 0, got_vec(), {6'b0, 8'd255});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
